fifo_wconv: RTL and testbench

//  Parametrised bit-granular width-converting FIFO: accepts WR_W-bit words, delivers RD_W-bit words.

---
 rtl/fifo_wconv_pkg.sv | 17 +
 rtl/fifo_wconv_bitmem.sv | 42 ++++
 rtl/fifo_wconv.sv | 118 +++++++++++
 tb/tb_fifo_wconv.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wconv_pkg.sv
// Shared types and helpers for the bit-granular width-converting FIFO.
package fifo_wconv_pkg;

    typedef struct packed {
        logic empty;
        logic half_full;
        logic full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Storage depth is a power of two, so wrapping is a mask.
    function automatic int unsigned ptr_wrap(input int unsigned idx, input int unsigned depth);
        return idx & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/fifo_wconv_bitmem.sv
// DEPTH-bit storage with a WR_W-bit scatter write port and an RD_W-bit gather read port.
module fifo_wconv_bitmem
    import fifo_wconv_pkg::*;
#(
    parameter int WR_W  = 8,
    parameter int RD_W  = 3,
    parameter int DEPTH = 128,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [WR_W-1:0]  data_w,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [RD_W-1:0]  rd_data
);

    logic [DEPTH-1:0] mem_r;

    // Scatter write: each incoming bit lands at its own wrapped index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= '0;
        end else if (we) begin
            for (int i = 0; i < WR_W; i++) begin
                mem_r[PTR_W'(ptr_wrap(32'(wr_ptr) + 32'(i), 32'(DEPTH)))] <= data_w[i];
            end
        end else begin
            mem_r <= mem_r;
        end
    end

    // Gather read of the RD_W oldest bits starting at rd_ptr.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < RD_W; i++) begin
            rd_data[i] = mem_r[PTR_W'(ptr_wrap(32'(rd_ptr) + 32'(i), 32'(DEPTH)))];
        end
    end

endmodule

// File: rtl/fifo_wconv.sv
// Width-converting FIFO: WR_W-bit words in, RD_W-bit words out, bit 0 first.
module fifo_wconv
    import fifo_wconv_pkg::*;
#(
    parameter int WR_W  = 8,
    parameter int RD_W  = 3,
    parameter int DEPTH = 128,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             w_en,
    input  logic [WR_W-1:0]  data_w,
    input  logic             r_en,
    output logic [RD_W-1:0]  data_r,
    output logic             rd_valid,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             half_full,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0] level_r, level_nxt_s;
    logic             overflow_r, underflow_r;
    logic             wr_ok_s, rd_ok_s, we_s;
    logic [RD_W-1:0]  rd_word_s;
    fifo_status_t     status_s;

    fifo_wconv_bitmem #(.WR_W(WR_W), .RD_W(RD_W), .DEPTH(DEPTH)) u_bitmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we_s),
        .wr_ptr  (wr_ptr_r),
        .data_w  (data_w),
        .rd_ptr  (rd_ptr_r),
        .rd_data (rd_word_s)
    );

    // Status flags decoded from the stored level; sticky errors come from registers.
    always_comb begin
        status_s.empty     = (level_r < LVL_W'(RD_W));
        status_s.half_full = (level_r >= LVL_W'(DEPTH / 2));
        status_s.full      = (level_r > LVL_W'(DEPTH - WR_W));
        status_s.overflow  = overflow_r;
        status_s.underflow = underflow_r;
    end

    // Accept decisions and next level; no same-cycle bypass from write to read.
    always_comb begin
        wr_ok_s     = w_en & ~status_s.full;
        rd_ok_s     = r_en & ~status_s.empty;
        we_s        = wr_ok_s & ~clr;
        level_nxt_s = level_r;
        if (wr_ok_s && rd_ok_s) begin
            level_nxt_s = level_r + LVL_W'(WR_W) - LVL_W'(RD_W);
        end else if (wr_ok_s) begin
            level_nxt_s = level_r + LVL_W'(WR_W);
        end else if (rd_ok_s) begin
            level_nxt_s = level_r - LVL_W'(RD_W);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Pointer, level, read-port and sticky-flag registers; flush keeps data_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            data_r      <= '0;
            rd_valid    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clr) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            rd_valid    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            level_r  <= level_nxt_s;
            rd_valid <= rd_ok_s;
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(WR_W);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(RD_W);
                data_r   <= rd_word_s;
            end
            // Setting the flag takes priority over clearing it in the same cycle.
            if (w_en && status_s.full) begin
                overflow_r <= 1'b1;
            end else if (rd_ok_s) begin
                overflow_r <= 1'b0;
            end
            if (r_en && status_s.empty) begin
                underflow_r <= 1'b1;
            end else if (wr_ok_s) begin
                underflow_r <= 1'b0;
            end
        end
    end

    assign level     = level_r;
    assign empty     = status_s.empty;
    assign half_full = status_s.half_full;
    assign full      = status_s.full;
    assign overflow  = status_s.overflow;
    assign underflow = status_s.underflow;

endmodule

// File: tb/tb_fifo_wconv.sv
// Self-checking bench for fifo_wconv against a bit-queue reference model.
module tb_fifo_wconv;

    localparam int WR_W  = 8;
    localparam int RD_W  = 3;
    localparam int DEPTH = 128;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             w_en = 1'b0;
    logic [WR_W-1:0]  data_w = '0;
    logic             r_en = 1'b0;
    logic [RD_W-1:0]  data_r;
    logic             rd_valid;
    logic [LVL_W-1:0] level;
    logic             empty, half_full, full, overflow, underflow;

    int n_cmp = 0;
    int n_fail = 0;

    bit              q[$];
    bit              ov_m, un_m, valid_m;
    logic [RD_W-1:0] data_m;

    fifo_wconv #(.WR_W(WR_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .data_w(data_w), .r_en(r_en),
        .data_r(data_r), .rd_valid(rd_valid), .level(level), .empty(empty),
        .half_full(half_full), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model applies the accept rules to the pre-edge queue.
    task automatic step(input logic w, input logic [WR_W-1:0] d, input logic r, input logic c);
        int lvl;
        bit full_m, empty_m, wok, rok;
        w_en = w; data_w = d; r_en = r; clr = c;
        lvl = q.size();
        full_m  = lvl > DEPTH - WR_W;
        empty_m = lvl < RD_W;
        wok = w && !full_m;
        rok = r && !empty_m;
        @(posedge clk); #1;
        if (c) begin
            q.delete(); ov_m = 0; un_m = 0; valid_m = 0;
        end else begin
            if (rok) for (int i = 0; i < RD_W; i++) data_m[i] = q.pop_front();
            if (wok) for (int i = 0; i < WR_W; i++) q.push_back(d[i]);
            valid_m = rok;
            if (w && full_m) ov_m = 1; else if (rok) ov_m = 0;
            if (r && empty_m) un_m = 1; else if (wok) un_m = 0;
        end
        w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
    endtask

    task automatic model_reset();
        q.delete(); ov_m = 0; un_m = 0; valid_m = 0; data_m = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({empty, half_full, full, overflow, underflow} !== 5'b10000 || level !== '0 || data_r !== '0) begin
            n_fail++;
            $display("FAIL reset_state: flags=%b level=%0d data_r=%0d, want flags=10000 level=0 data_r=0",
                     {empty, half_full, full, overflow, underflow}, level, data_r);
        end
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({empty, half_full, full, overflow, underflow} !== 5'b10000 || level !== '0
            || data_r !== '0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midstream: flags=%b level=%0d data_r=%0d rd_valid=%b, want 10000/0/0/0",
                     {empty, half_full, full, overflow, underflow}, level, data_r, rd_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_read();
        logic [RD_W-1:0] exp_words [4] = '{3'd1, 3'd0, 3'd0, 3'd1};
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(16)) begin
            n_fail++; $display("FAIL basic_level16: level=%0d want 16", level);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (data_r !== exp_words[k] || rd_valid !== 1'b1 || data_r !== data_m) begin
                n_fail++;
                $display("FAIL basic_read%0d: data_r=%0d rd_valid=%b want %0d/1", k, data_r, rd_valid, exp_words[k]);
            end
        end
        n_cmp++;
        if (level !== LVL_W'(4)) begin
            n_fail++; $display("FAIL basic_level4: level=%0d want 4", level);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int k = 1; k <= 8; k++) step(1'b1, WR_W'(k), 1'b0, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(64) || half_full !== 1'b1 || full !== 1'b0) begin
            n_fail++; $display("FAIL fill_half: level=%0d hf=%b full=%b want 64/1/0", level, half_full, full);
        end
        for (int k = 9; k <= 16; k++) step(1'b1, WR_W'(k), 1'b0, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(128) || full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: level=%0d full=%b ovf=%b want 128/1/0", level, full, overflow);
        end
        step(1'b1, 8'd99, 1'b0, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(128) || overflow !== 1'b1) begin
            n_fail++; $display("FAIL fill_overflow: level=%0d ovf=%b want 128/1", level, overflow);
        end
    endtask

    task automatic test_drain();
        for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(116) || overflow !== 1'b0 || full !== 1'b0 || half_full !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_116: level=%0d ovf=%b full=%b hf=%b want 116/0/0/1", level, overflow, full, half_full);
        end
        step(1'b1, 8'd1, 1'b0, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(124) || full !== 1'b1) begin
            n_fail++; $display("FAIL drain_124: level=%0d full=%b want 124/1", level, full);
        end
        step(1'b1, 8'd2, 1'b0, 1'b0);
        n_cmp++;
        if (overflow !== 1'b1 || level !== LVL_W'(124)) begin
            n_fail++; $display("FAIL drain_reovf: ovf=%b level=%0d want 1/124", overflow, level);
        end
        for (int k = 0; k < 41; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (data_r !== data_m || rd_valid !== 1'b1) begin
                n_fail++; $display("FAIL drain_word%0d: data_r=%0d rd_valid=%b want %0d/1", k, data_r, rd_valid, data_m);
            end
        end
        n_cmp++;
        if (level !== LVL_W'(1) || empty !== 1'b1) begin
            n_fail++; $display("FAIL drain_empty: level=%0d empty=%b want 1/1", level, empty);
        end
    endtask

    task automatic test_underflow();
        logic [RD_W-1:0] held;
        held = data_m;
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (underflow !== 1'b1 || rd_valid !== 1'b0 || data_r !== held || level !== LVL_W'(1)) begin
            n_fail++;
            $display("FAIL underflow_set: unf=%b rd_valid=%b data_r=%0d level=%0d want 1/0/%0d/1",
                     underflow, rd_valid, data_r, level, held);
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        n_cmp++;
        if (underflow !== 1'b0 || level !== LVL_W'(9)) begin
            n_fail++; $display("FAIL underflow_clear: unf=%b level=%0d want 0/9", underflow, level);
        end
    endtask

    task automatic test_simul_clr();
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(8) || rd_valid !== 1'b1 || data_r !== data_m) begin
            n_fail++;
            $display("FAIL simul_rw: level=%0d rd_valid=%b data_r=%0d want 8/1/%0d", level, rd_valid, data_r, data_m);
        end
        for (int k = 0; k < 6; k++) step(1'b1, WR_W'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if (level !== LVL_W'(50)) begin
            n_fail++; $display("FAIL clr_prep: level=%0d want 50", level);
        end
        step(1'b1, 8'h11, 1'b1, 1'b1);
        n_cmp++;
        if (level !== '0 || {empty, half_full, full, overflow, underflow} !== 5'b10000
            || rd_valid !== 1'b0 || data_r !== data_m) begin
            n_fail++;
            $display("FAIL clr_flush: level=%0d flags=%b rd_valid=%b data_r=%0d want 0/10000/0/%0d",
                     level, {empty, half_full, full, overflow, underflow}, rd_valid, data_r, data_m);
        end
    endtask

    task automatic test_random();
        int pw;
        int lvl;
        logic [LVL_W+7+RD_W-1:0] got, exp;
        for (int blk = 0; blk < 20; blk++) begin
            pw = $urandom_range(15, 85);
            for (int k = 0; k < 500; k++) begin
                step($urandom_range(0, 99) < pw, WR_W'($urandom), $urandom_range(0, 99) < 50,
                     $urandom_range(0, 999) == 0);
                lvl = q.size();
                got = {level, empty, half_full, full, overflow, underflow, rd_valid, 1'b0, data_r};
                exp = {LVL_W'(lvl), lvl < RD_W, lvl >= DEPTH / 2, lvl > DEPTH - WR_W,
                       ov_m, un_m, valid_m, 1'b0, data_m};
                n_cmp++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random_blk%0d_cyc%0d: got=%h want=%h", blk, k, got, exp);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_read();
        test_fill_overflow();
        test_drain();
        test_underflow();
        test_simul_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
